// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory access sequencer:
// word width, sequencer states and request kinds.
package mem_access_unit_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } kind_t;

endpackage

// File: rtl/mem_access_unit.sv
// Multi-cycle sequencer for fetch/load/store on a single-ported memory.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
import mem_access_unit_pkg::*;

module mem_access_unit #(
  parameter int WORD_SIZE = mem_access_unit_pkg::WORD_SIZE,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 fetch_req,
  input  logic                 rd_req,
  input  logic                 wr_req,
  input  logic [WORD_SIZE-1:0] pc,
  input  logic [WORD_SIZE-1:0] data_addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] instruction,
  output logic [WORD_SIZE-1:0] mdr,
  output logic                 err,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 input_ready,
  input  logic                 ack_output
);

  state_t state;
  kind_t  kind;
  logic   hit;

  // completion strobe for the transaction in flight
  assign hit = (kind == WRITE) ? ack_output : input_ready;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tcount;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign err = 1'b0;
`endif

  // sequencer: accept in IDLE, wait in ACCESS, one-cycle DONE
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      kind        <= FETCH;
      busy        <= 1'b0;
      done        <= 1'b0;
      readM       <= 1'b0;
      writeM      <= 1'b0;
      address     <= '0;
      mem_wdata   <= '0;
      instruction <= '0;
      mdr         <= '0;
`ifdef MEM_TIMEOUT_EN
      err         <= 1'b0;
      tcount      <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
`ifdef MEM_TIMEOUT_EN
          tcount <= '0;
`endif
          if (fetch_req) begin
            kind    <= FETCH;
            address <= pc;
            readM   <= 1'b1;
            busy    <= 1'b1;
            state   <= ACCESS;
          end else if (rd_req) begin
            kind    <= READ;
            address <= data_addr;
            readM   <= 1'b1;
            busy    <= 1'b1;
            state   <= ACCESS;
          end else if (wr_req) begin
            kind      <= WRITE;
            address   <= data_addr;
            mem_wdata <= wr_data;
            writeM    <= 1'b1;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (hit) begin
            if (kind == FETCH) instruction <= mem_rdata;
            if (kind == READ)  mdr         <= mem_rdata;
            readM  <= 1'b0;
            writeM <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (tcount == CW'(TIMEOUT - 1)) begin
            err    <= 1'b1;
            readM  <= 1'b0;
            writeM <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            tcount <= tcount + 1'b1;
          end
`endif
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
// Timeout cases run only when MEM_TIMEOUT_EN is defined.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_req, rd_req, wr_req;
  logic [15:0] pc, data_addr, wr_data;
  logic        busy, done, err, readM, writeM;
  logic [15:0] instruction, mdr, address, mem_wdata, mem_rdata;
  logic        input_ready, ack_output;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_req(fetch_req), .rd_req(rd_req), .wr_req(wr_req),
    .pc(pc), .data_addr(data_addr), .wr_data(wr_data),
    .busy(busy), .done(done),
    .instruction(instruction), .mdr(mdr), .err(err),
    .readM(readM), .writeM(writeM),
    .address(address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .input_ready(input_ready), .ack_output(ack_output)
  );

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    fetch_req = 0; rd_req = 0; wr_req = 0;
    pc = 0; data_addr = 0; wr_data = 0;
    mem_rdata = 0; input_ready = 0; ack_output = 0;
    tick(); tick();
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_readM", 16'(readM), 16'h0);
    chk("rst_writeM", 16'(writeM), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    chk("rst_addr", address, 16'h0);
    chk("rst_ir", instruction, 16'h0);
    chk("rst_mdr", mdr, 16'h0);
    reset_n = 1'b1;
    tick();

    // stray strobe in IDLE
    input_ready = 1; mem_rdata = 16'h1234;
    tick(); tick();
    chk("stray_busy", 16'(busy), 16'h0);
    chk("stray_done", 16'(done), 16'h0);
    chk("stray_ir", instruction, 16'h0);
    chk("stray_mdr", mdr, 16'h0);
    input_ready = 0;

    // fetch, ready 3 cycles after readM
    pc = 16'h0010; fetch_req = 1;
    tick();
    chk("f_readM0", 16'(readM), 16'h1);
    chk("f_addr", address, 16'h0010);
    chk("f_busy", 16'(busy), 16'h1);
    fetch_req = 0;
    tick();
    chk("f_readM1", 16'(readM), 16'h1);
    tick();
    chk("f_readM2", 16'(readM), 16'h1);
    chk("f_done_early", 16'(done), 16'h0);
    input_ready = 1; mem_rdata = 16'hF01C;
    tick();
    chk("f_readM3", 16'(readM), 16'h0);
    chk("f_done", 16'(done), 16'h1);
    chk("f_ir", instruction, 16'hF01C);
    chk("f_mdr", mdr, 16'h0);
    chk("f_busy_end", 16'(busy), 16'h0);
    input_ready = 0;
    tick();
    chk("f_done_off", 16'(done), 16'h0);

    // store, ack after 2 cycles
    data_addr = 16'h0040; wr_data = 16'hBEEF; wr_req = 1;
    tick();
    chk("w_writeM0", 16'(writeM), 16'h1);
    chk("w_readM0", 16'(readM), 16'h0);
    chk("w_addr0", address, 16'h0040);
    chk("w_wdata0", mem_wdata, 16'hBEEF);
    wr_req = 0; wr_data = 16'h0000; data_addr = 16'h0000;
    tick();
    chk("w_writeM1", 16'(writeM), 16'h1);
    chk("w_addr1", address, 16'h0040);
    chk("w_wdata1", mem_wdata, 16'hBEEF);
    ack_output = 1;
    tick();
    chk("w_done", 16'(done), 16'h1);
    chk("w_writeM2", 16'(writeM), 16'h0);
    chk("w_ir", instruction, 16'hF01C);
    chk("w_mdr", mdr, 16'h0);
    ack_output = 0;
    tick();

    // fetch beats read; read follows after DONE
    pc = 16'h0020; data_addr = 16'h0080;
    fetch_req = 1; rd_req = 1;
    tick();
    chk("p_addr", address, 16'h0020);
    input_ready = 1; mem_rdata = 16'h1111;
    tick();
    chk("p_done", 16'(done), 16'h1);
    chk("p_ir", instruction, 16'h1111);
    chk("p_mdr", mdr, 16'h0);
    fetch_req = 0; input_ready = 0;
    tick();
    chk("p_idle_busy", 16'(busy), 16'h0);
    tick();
    chk("r_readM", 16'(readM), 16'h1);
    chk("r_addr", address, 16'h0080);
    input_ready = 1; mem_rdata = 16'h2222;
    tick();
    chk("r_done", 16'(done), 16'h1);
    chk("r_mdr", mdr, 16'h2222);
    chk("r_ir", instruction, 16'h1111);
    rd_req = 0; input_ready = 0;
    tick(); tick();
    chk("r_idle", 16'(busy), 16'h0);

    // reset mid-read
    data_addr = 16'h0090; rd_req = 1;
    tick();
    rd_req = 0;
    tick();
    chk("x_readM_pre", 16'(readM), 16'h1);
    reset_n = 0;
    tick();
    chk("x_readM", 16'(readM), 16'h0);
    chk("x_busy", 16'(busy), 16'h0);
    chk("x_ir", instruction, 16'h0);
    chk("x_mdr", mdr, 16'h0);
    chk("x_addr", address, 16'h0);
    reset_n = 1;
    input_ready = 1; mem_rdata = 16'h3333;
    tick(); tick();
    chk("x_late_done", 16'(done), 16'h0);
    chk("x_late_mdr", mdr, 16'h0);
    chk("x_late_ir", instruction, 16'h0);
    input_ready = 0;
    tick();

`ifdef MEM_TIMEOUT_EN
    pc = 16'h0050; fetch_req = 1;
    tick();
    fetch_req = 0;
    for (int i = 0; i < 14; i++) tick();
    chk("t_readM_hold", 16'(readM), 16'h1);
    chk("t_err_pre", 16'(err), 16'h0);
    tick();
    chk("t_readM", 16'(readM), 16'h0);
    chk("t_err", 16'(err), 16'h1);
    chk("t_done", 16'(done), 16'h1);
    chk("t_ir", instruction, 16'h0);
    tick();
    pc = 16'h0060; fetch_req = 1;
    tick();
    fetch_req = 0;
    input_ready = 1; mem_rdata = 16'h4444;
    tick();
    chk("t2_ir", instruction, 16'h4444);
    chk("t2_err", 16'(err), 16'h1);
    input_ready = 0;
    tick();
`else
    chk("no_to_err", 16'(err), 16'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle memory sequencer between the TSC datapath/control unit and the single-ported 16-bit memory. It serves instruction-fetch, data-read and data-write requests issued during the IF and MEM micro-states. It drives the readM/writeM/address handshake, waits for the memory's completion strobe, and holds the fetched instruction (IR) and loaded data (MDR) stable for the ID/EX/WB stages.

## Interface
- WORD_SIZE, 16, data/address width
- TIMEOUT, 15, max wait cycles in ACCESS (used only with MEM_TIMEOUT_EN)

Reset: reset_n, synchronous, active-low. Clock: clk.

- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- fetch_req  in  1  instruction-fetch request, level
- rd_req  in  1  data-read request (LWD)
- wr_req  in  1  data-write request (SWD)
- pc  in  WORD_SIZE  fetch address
- data_addr  in  WORD_SIZE  load/store address
- wr_data  in  WORD_SIZE  store data
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- instruction  out  WORD_SIZE  IR, feeds control unit and datapath
- mdr  out  WORD_SIZE  loaded data
- err  out  1  sticky timeout flag
- readM  out  1  memory read strobe
- writeM  out  1  memory write strobe
- address  out  WORD_SIZE  memory address
- mem_wdata  out  WORD_SIZE  memory write data
- mem_rdata  in  WORD_SIZE  memory read data
- input_ready  in  1  read data valid
- ack_output  in  1  write accepted

## Operation
- States: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE: requests are sampled each edge. Priority is fetch > rd > wr. Lower-priority requests asserted in the same cycle are dropped, not queued.
- On accept, the unit latches the kind (FETCH/READ/WRITE) and sets address to pc or data_addr.
  - WRITE also sets mem_wdata = wr_data.
  - readM = 1 for FETCH/READ; writeM = 1 for WRITE.
  - busy = 1; next state ACCESS.
- ACCESS: the unit holds address, strobes and mem_wdata constant.
  - FETCH/READ complete on input_ready = 1. FETCH captures instruction <= mem_rdata; READ captures mdr <= mem_rdata.
  - WRITE completes on ack_output = 1.
  - Completion edge: strobes drop to 0, done <= 1, busy <= 0, next state DONE.
- DONE: lasts one cycle; done returns to 0 and the state goes to IDLE. Requests are not sampled in DONE, which gives the requester one cycle to deassert.
- instruction and mdr change only on their own capture edge. A READ never alters instruction.
- Strobes seen outside ACCESS (input_ready/ack_output in IDLE or DONE) are ignored.
- Reset (any state, mid-transaction included):
  - state IDLE;
  - busy, done, readM, writeM and err = 0;
  - address, mem_wdata, instruction and mdr = 0.
  - An aborted write may or may not have reached memory.

## Timing
- Request high at edge e0 (IDLE): readM/writeM and address valid from e0.
- Completion strobe first sampled at e1 or later, edge ek. Data is captured at ek; done is high for the cycle ek..ek+1.
- Minimum request-to-done latency: 2 edges. Minimum back-to-back spacing: 3 edges (IDLE, ACCESS, DONE).
- A request held continuously high is re-accepted at the IDLE edge after DONE. The requester must drop it on done.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle.
  - When it reaches TIMEOUT without a strobe: strobes drop, err <= 1 (sticky until reset), done pulses, no capture.
- Undefined: ACCESS waits indefinitely; err is constant 0 and no counter exists.

## Structure
- The shared package (alongside opcodes.v) holds:
  - WORD_SIZE;
  - state encodings (IDLE/ACCESS/DONE);
  - request-kind encodings (FETCH/READ/WRITE).
- Single module. The timeout counter is inline under the macro, with no sub-module.

## Test plan
- Fetch: pc=0x0010, fetch_req=1, input_ready asserted 3 cycles after readM with mem_rdata=0xF01C -> instruction=0xF01C, done one cycle, readM high exactly 3 cycles, mdr unchanged.
- Store: wr_req, data_addr=0x0040, wr_data=0xBEEF, ack_output after 2 cycles -> writeM/address/mem_wdata stable throughout, done pulse, instruction and mdr unchanged.
- Simultaneous fetch_req+rd_req -> only the fetch is performed. With rd_req still high after done, a read of data_addr follows, and mdr=mem_rdata of that read.
- reset_n=0 in ACCESS mid-read -> next edge: readM=0, busy=0, instruction=0, mdr=0; a late input_ready is ignored.
- MEM_TIMEOUT_EN, TIMEOUT=15, no strobe -> readM drops after 15 ACCESS cycles, err=1, done pulses, instruction unchanged. err stays 1 through a later successful fetch.
- Stray input_ready in IDLE with no request -> no state change, no done, no capture.
